// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight loader: default bus widths and FSM state encoding.
package weight_loader_pkg;

    localparam int unsigned WL_ADDR_WIDTH = 32;
    localparam int unsigned WL_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } wl_state_e;

endpackage

// File: rtl/weight_loader.sv
// Weight loader: accepts a (base, count) command, then streams count words into
// broadcast weight writes at consecutive addresses, pulsing done at completion.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = WL_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = WL_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_count,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] weight_wr_data,
    output logic [ADDR_WIDTH-1:0] weight_wr_addr,
    output logic                  weight_wr_en,
    output logic                  busy,
    output logic                  done
);

    wl_state_e               state_q, state_d;
    logic                    live_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   remain_q, remain_d;
    logic                    wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic                    cmd_fire, beat_fire;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign beat_fire = s_valid && s_ready;

    // live_q keeps cmd_ready low while rst is held and raises it on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_d = (cmd_count == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat_fire && remain_q == ADDR_WIDTH'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE) && live_q;
        s_ready   = (state_q == ST_LOAD);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
    end

    always_comb begin
        addr_d    = addr_q;
        remain_d  = remain_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        if (cmd_fire) begin
            addr_d   = cmd_base_addr;
            remain_d = cmd_count;
        end else if (beat_fire) begin
            wr_en_d   = 1'b1;
            wr_data_d = s_data;
            wr_addr_d = addr_q;
            addr_d    = addr_q + ADDR_WIDTH'(1);
            remain_d  = remain_q - ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            remain_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
        end else begin
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign weight_wr_en   = wr_en_q;
    assign weight_wr_data = wr_data_q;
    assign weight_wr_addr = wr_addr_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: each task drives one scenario and checks against hand-computed values.
module tb_weight_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd_base_addr;
    logic [31:0] cmd_count;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] weight_wr_data;
    logic [31:0] weight_wr_addr;
    logic        weight_wr_en;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    weight_loader #(.ADDR_WIDTH(32), .DATA_WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_base_addr  (cmd_base_addr),
        .cmd_count      (cmd_count),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .weight_wr_data (weight_wr_data),
        .weight_wr_addr (weight_wr_addr),
        .weight_wr_en   (weight_wr_en),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] base, input logic [31:0] count);
        int unsigned n;
        cmd_base_addr = base;
        cmd_count     = count;
        cmd_valid     = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_accept base=%h got cmd_ready=%b exp 1", base, cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if ({weight_wr_en, done, busy, s_ready, cmd_ready} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_ctrl got en,done,busy,s_rdy,c_rdy=%b exp 00000",
                     {weight_wr_en, done, busy, s_ready, cmd_ready});
        end
        vectors++;
        if (weight_wr_addr !== 32'h0 || weight_wr_data !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_bus got addr=%h data=%h exp 0/0", weight_wr_addr, weight_wr_data);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_before_edge got cmd_ready=%b exp 0", cmd_ready);
        end
        step();
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_edge got cmd_ready=%b exp 1", cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [4];
        words[0] = 16'h0011; words[1] = 16'h0022; words[2] = 16'h0033; words[3] = 16'h0044;
        send_cmd(32'd23, 32'd4);
        vectors++;
        if (s_ready !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_load_entry got s_rdy=%b busy=%b c_rdy=%b exp 1 1 0", s_ready, busy, cmd_ready);
        end
        for (int i = 0; i < 4; i++) begin
            s_data  = words[i];
            s_valid = 1'b1;
            step();
            vectors++;
            if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd23 + 32'(i) || weight_wr_data !== words[i]) begin
                miscompares++;
                $display("FAIL b2b_write[%0d] got en=%b addr=%0d data=%h exp 1 %0d %h",
                         i, weight_wr_en, weight_wr_addr, weight_wr_data, 23 + i, words[i]);
            end
            vectors++;
            if (done !== (i == 3)) begin
                miscompares++;
                $display("FAIL b2b_done[%0d] got %b exp %b", i, done, (i == 3));
            end
        end
        s_valid = 1'b0;
        step();
        vectors++;
        if (weight_wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_idle got en=%b done=%b busy=%b c_rdy=%b exp 0 0 0 1",
                     weight_wr_en, done, busy, cmd_ready);
        end
        vectors++;
        if (weight_wr_addr !== 32'd26 || weight_wr_data !== 16'h0044) begin
            miscompares++;
            $display("FAIL b2b_hold got addr=%0d data=%h exp 26 0044", weight_wr_addr, weight_wr_data);
        end
    endtask

    task automatic test_gaps();
        int strobes = 0;
        send_cmd(32'd100, 32'd3);
        for (int i = 0; i < 3; i++) begin
            s_data  = 16'h00A0 + 16'(i);
            s_valid = 1'b1;
            step();
            if (weight_wr_en === 1'b1) strobes++;
            vectors++;
            if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd100 + 32'(i) || done !== (i == 2)) begin
                miscompares++;
                $display("FAIL gap_write[%0d] got en=%b addr=%0d done=%b exp 1 %0d %b",
                         i, weight_wr_en, weight_wr_addr, done, 100 + i, (i == 2));
            end
            s_valid = 1'b0;
            if (i < 2) begin
                for (int g = 0; g < 2; g++) begin
                    step();
                    if (weight_wr_en === 1'b1) strobes++;
                    vectors++;
                    if (weight_wr_en !== 1'b0 || busy !== 1'b1 || weight_wr_addr !== 32'd100 + 32'(i)) begin
                        miscompares++;
                        $display("FAIL gap_idle[%0d.%0d] got en=%b busy=%b addr=%0d exp 0 1 %0d",
                                 i, g, weight_wr_en, busy, weight_wr_addr, 100 + i);
                    end
                end
            end
        end
        step();
        if (weight_wr_en === 1'b1) strobes++;
        vectors++;
        if (strobes !== 3 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_total got strobes=%0d busy=%b exp 3 0", strobes, busy);
        end
    endtask

    task automatic test_zero_count();
        s_data  = 16'hDEAD;
        s_valid = 1'b1;
        #1;
        vectors++;
        if (s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_consume got s_ready=%b exp 0", s_ready);
        end
        send_cmd(32'd5, 32'd0);
        vectors++;
        if (done !== 1'b1 || weight_wr_en !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_done got done=%b en=%b c_rdy=%b busy=%b s_rdy=%b exp 1 0 0 1 0",
                     done, weight_wr_en, cmd_ready, busy, s_ready);
        end
        step();
        vectors++;
        if (done !== 1'b0 || weight_wr_en !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_after got done=%b en=%b c_rdy=%b busy=%b exp 0 0 1 0",
                     done, weight_wr_en, cmd_ready, busy);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [2];
        logic [15:0] dat [2];
        exp_a[0] = 32'hFFFF_FFFF; exp_a[1] = 32'h0000_0000;
        dat[0] = 16'h0BEE; dat[1] = 16'h0CAF;
        send_cmd(32'hFFFF_FFFF, 32'd2);
        for (int i = 0; i < 2; i++) begin
            s_data  = dat[i];
            s_valid = 1'b1;
            step();
            vectors++;
            if (weight_wr_en !== 1'b1 || weight_wr_addr !== exp_a[i] || weight_wr_data !== dat[i]) begin
                miscompares++;
                $display("FAIL wrap_write[%0d] got en=%b addr=%h data=%h exp 1 %h %h",
                         i, weight_wr_en, weight_wr_addr, weight_wr_data, exp_a[i], dat[i]);
            end
        end
        s_valid = 1'b0;
        step();
    endtask

    task automatic test_overrun();
        send_cmd(32'd200, 32'd2);
        s_valid = 1'b1;
        s_data  = 16'h0001;
        cmd_base_addr = 32'd300;
        cmd_count     = 32'd1;
        cmd_valid     = 1'b1;
        #1;
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL over_cmd_hold_load got cmd_ready=%b exp 0", cmd_ready);
        end
        step();
        vectors++;
        if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd200 || weight_wr_data !== 16'h0001) begin
            miscompares++;
            $display("FAIL over_write0 got en=%b addr=%0d data=%h exp 1 200 0001",
                     weight_wr_en, weight_wr_addr, weight_wr_data);
        end
        s_data = 16'h0002;
        step();
        vectors++;
        if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd201 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL over_write1 got en=%b addr=%0d done=%b exp 1 201 1",
                     weight_wr_en, weight_wr_addr, done);
        end
        s_data = 16'h0003;
        vectors++;
        if (s_ready !== 1'b0 || cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL over_done_stall got s_rdy=%b c_rdy=%b exp 0 0", s_ready, cmd_ready);
        end
        step();
        vectors++;
        if (weight_wr_en !== 1'b0 || s_ready !== 1'b0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL over_no_third got en=%b s_rdy=%b c_rdy=%b exp 0 0 1", weight_wr_en, s_ready, cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
        vectors++;
        if (s_ready !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL over_second_cmd got s_rdy=%b busy=%b exp 1 1", s_ready, busy);
        end
        step();
        vectors++;
        if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd300 || weight_wr_data !== 16'h0003 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL over_second_write got en=%b addr=%0d data=%h done=%b exp 1 300 0003 1",
                     weight_wr_en, weight_wr_addr, weight_wr_data, done);
        end
        s_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        send_cmd(32'd50, 32'd8);
        for (int i = 0; i < 2; i++) begin
            s_data  = 16'h0050 + 16'(i);
            s_valid = 1'b1;
            step();
            vectors++;
            if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd50 + 32'(i)) begin
                miscompares++;
                $display("FAIL abort_write[%0d] got en=%b addr=%0d exp 1 %0d",
                         i, weight_wr_en, weight_wr_addr, 50 + i);
            end
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({weight_wr_en, done, busy, s_ready, cmd_ready} !== 5'b00000) begin
            miscompares++;
            $display("FAIL abort_immediate got en,done,busy,s_rdy,c_rdy=%b exp 00000",
                     {weight_wr_en, done, busy, s_ready, cmd_ready});
        end
        for (int k = 0; k < 2; k++) begin
            step();
            if (done === 1'b1 || weight_wr_en === 1'b1) dones++;
        end
        s_valid = 1'b0;
        rst = 1'b0;
        step();
        if (done === 1'b1 || weight_wr_en === 1'b1) dones++;
        vectors++;
        if (dones !== 0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_quiet got strobes_or_done=%0d c_rdy=%b busy=%b exp 0 1 0", dones, cmd_ready, busy);
        end
        send_cmd(32'd60, 32'd1);
        s_data  = 16'h0077;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        vectors++;
        if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd60 || weight_wr_data !== 16'h0077 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_recover got en=%b addr=%0d data=%h done=%b exp 1 60 0077 1",
                     weight_wr_en, weight_wr_addr, weight_wr_data, done);
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        cmd_base_addr = '0;
        cmd_count = '0;
        cmd_valid = 1'b0;
        s_data = '0;
        s_valid = 1'b0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_zero_count();
        test_wrap();
        test_overrun();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
